// File: rtl/jump_controller_if.sv
// Player-side signal bundle for the jump controller.
//
// Handshake: a jump request is the rising edge of jump_req (a level held high
// produces one request). The controller answers an accepted request with a
// one-cycle jump_ack pulse; rejected requests get no answer. pause is a level
// that freezes motion and drops requests while high. ball_height, phase,
// airborne and landed are status outputs valid every cycle.
interface jump_controller_if #(
    parameter int H_W = 3
);
    logic           jump_req;
    logic           pause;
    logic [H_W-1:0] ball_height;
    logic [1:0]     phase;
    logic           airborne;
    logic           jump_ack;
    logic           landed;

    // Game/input logic side
    modport master (
        output jump_req,
        output pause,
        input  ball_height,
        input  phase,
        input  airborne,
        input  jump_ack,
        input  landed
    );

    // Controller side
    modport slave (
        input  jump_req,
        input  pause,
        output ball_height,
        output phase,
        output airborne,
        output jump_ack,
        output landed
    );
endinterface

// File: rtl/jump_controller.sv
// Ball vertical-motion sequencer: GROUND -> RISE -> APEX -> FALL driven by a
// prescaled game tick. A jump edge close to landing is buffered and launches
// the next jump on the landing tick.
// Optional build macro JUMP_CTRL_DOUBLE_JUMP_EN adds one mid-air re-jump per
// flight (from APEX, or from FALL above the buffer height).
// The FSM state is visible directly on bus.phase.
module jump_controller #(
    parameter int TICK_LOG2  = 23,
    parameter int H_W        = 3,
    parameter int MAX_H      = 5,
    parameter int APEX_TICKS = 1,
    parameter int BUF_H      = 1
) (
    input  logic               clk,
    input  logic               rst,
    jump_controller_if.slave   bus
);

    localparam int AW = (APEX_TICKS < 2) ? 1 : $clog2(APEX_TICKS + 1);
    localparam logic [H_W-1:0] MAX_HV    = H_W'(MAX_H);
    localparam logic [H_W-1:0] BUF_HV    = H_W'(BUF_H);
    localparam logic [AW-1:0]  APEX_INIT = AW'(APEX_TICKS);

    typedef enum logic [1:0] {
        S_GROUND = 2'd0,
        S_RISE   = 2'd1,
        S_APEX   = 2'd2,
        S_FALL   = 2'd3
    } state_t;

    state_t               state, state_n;
    logic [H_W-1:0]       height, height_n;
    logic [AW-1:0]        apex_cnt, apex_n;
    logic                 pending, pending_n;
    logic                 ack, ack_n;
    logic                 land, land_n;
    logic                 jump_q;
    logic [TICK_LOG2-1:0] presc;

`ifdef JUMP_CTRL_DOUBLE_JUMP_EN
    logic                 double_used, double_n;
`endif

    logic           tick;
    logic           jump_edge;
    logic           buf_edge;
    logic [H_W-1:0] h_up;
    logic [H_W-1:0] h_dn;

    // Pause suppresses both the tick and any request edge.
    assign tick      = (presc == '1) && !bus.pause;
    assign jump_edge = bus.jump_req && !jump_q && !bus.pause;
    assign buf_edge  = jump_edge && (height <= BUF_HV);

    // Saturating neighbours keep height inside 0..MAX_H.
    assign h_up = (height >= MAX_HV) ? MAX_HV : height + H_W'(1);
    assign h_dn = (height == '0) ? '0 : height - H_W'(1);

    // Prescaler, edge-detect history and all FSM/output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_GROUND;
            height   <= '0;
            apex_cnt <= '0;
            pending  <= 1'b0;
            ack      <= 1'b0;
            land     <= 1'b0;
            jump_q   <= 1'b1;
            presc    <= '0;
`ifdef JUMP_CTRL_DOUBLE_JUMP_EN
            double_used <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            height   <= height_n;
            apex_cnt <= apex_n;
            pending  <= pending_n;
            ack      <= ack_n;
            land     <= land_n;
            jump_q   <= bus.jump_req;
            if (!bus.pause) begin
                presc <= presc + TICK_LOG2'(1);
            end
`ifdef JUMP_CTRL_DOUBLE_JUMP_EN
            double_used <= double_n;
`endif
        end
    end

    // Next-state, next-height and event pulses for the trajectory FSM.
    always_comb begin
        state_n   = state;
        height_n  = height;
        apex_n    = apex_cnt;
        pending_n = pending;
        ack_n     = 1'b0;
        land_n    = 1'b0;
`ifdef JUMP_CTRL_DOUBLE_JUMP_EN
        double_n  = double_used;
`endif

        case (state)
            S_GROUND: begin
                // A tick in the launch cycle does not move the ball.
                if (jump_edge) begin
                    state_n = S_RISE;
                    ack_n   = 1'b1;
                end
            end

            S_RISE: begin
                if (tick) begin
                    height_n = h_up;
                    // Also covers a re-rise that starts at the apex height.
                    if (h_up == MAX_HV) begin
                        if (APEX_TICKS == 0) begin
                            state_n = S_FALL;
                        end else begin
                            state_n = S_APEX;
                            apex_n  = APEX_INIT;
                        end
                    end
                end
            end

            S_APEX: begin
`ifdef JUMP_CTRL_DOUBLE_JUMP_EN
                if (jump_edge && !double_used) begin
                    state_n  = S_RISE;
                    ack_n    = 1'b1;
                    double_n = 1'b1;
                end else
`endif
                if (tick) begin
                    if (apex_cnt <= AW'(1)) begin
                        apex_n  = '0;
                        state_n = S_FALL;
                    end else begin
                        apex_n  = apex_cnt - AW'(1);
                    end
                end
            end

            S_FALL: begin
`ifdef JUMP_CTRL_DOUBLE_JUMP_EN
                if (jump_edge && !buf_edge && !double_used) begin
                    state_n  = S_RISE;
                    ack_n    = 1'b1;
                    double_n = 1'b1;
                end else
`endif
                begin
                    if (buf_edge) begin
                        pending_n = 1'b1;
                    end
                    if (tick) begin
                        height_n = h_dn;
                        if (h_dn == '0) begin
                            land_n = 1'b1;
`ifdef JUMP_CTRL_DOUBLE_JUMP_EN
                            double_n = 1'b0;
`endif
                            // An edge on the landing tick itself is consumed here.
                            if (pending || buf_edge) begin
                                state_n   = S_RISE;
                                ack_n     = 1'b1;
                                pending_n = 1'b0;
                            end else begin
                                state_n   = S_GROUND;
                            end
                        end
                    end
                end
            end

            default: begin
                state_n = S_GROUND;
            end
        endcase
    end

    assign bus.ball_height = height;
    assign bus.phase       = state;
    assign bus.airborne    = (state != S_GROUND);
    assign bus.jump_ack    = ack;
    assign bus.landed      = land;

endmodule

// File: tb/tb_jump_controller.sv
// Directed bench for jump_controller with a 4-cycle tick (TICK_LOG2=2),
// MAX_H=5, APEX_TICKS=1, BUF_H=1.
`timescale 1ns/1ps
module tb_jump_controller;

  localparam int TICK_LOG2  = 2;
  localparam int H_W        = 3;
  localparam int MAX_H      = 5;
  localparam int APEX_TICKS = 1;
  localparam int BUF_H      = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jump_controller_if #(.H_W(H_W)) bus ();

  jump_controller #(
    .TICK_LOG2 (TICK_LOG2),
    .H_W       (H_W),
    .MAX_H     (MAX_H),
    .APEX_TICKS(APEX_TICKS),
    .BUF_H     (BUF_H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Records filled by watch_landing
  logic [H_W-1:0] exp_q[$];
  logic [H_W-1:0] h_q[$];
  int             gap_q[$];
  logic [1:0]     ph_q[$];
  int             ack_cnt;
  int             land_cnt;
  int             land_cyc;
  logic           ack_at_land;
  logic [1:0]     phase_at_land;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_hp(input logic [H_W-1:0] h, input logic [1:0] ph,
                         input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (bus.ball_height === h && bus.phase === ph) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Steps until a landed pulse (inclusive), logging height/phase changes.
  task automatic watch_landing(input int budget);
    logic [H_W-1:0] last_h;
    logic [1:0]     last_ph;
    int             last_c;
    h_q.delete(); gap_q.delete(); ph_q.delete();
    ack_cnt = 0; land_cnt = 0; land_cyc = -1;
    ack_at_land = 1'b0; phase_at_land = 2'bxx;
    last_h = bus.ball_height; last_ph = bus.phase; last_c = cyc;
    for (int i = 0; i < budget; i++) begin
      step();
      if (bus.ball_height !== last_h) begin
        h_q.push_back(bus.ball_height);
        gap_q.push_back(cyc - last_c);
        last_h = bus.ball_height;
        last_c = cyc;
      end
      if (bus.phase !== last_ph) begin
        ph_q.push_back(bus.phase);
        last_ph = bus.phase;
      end
      if (bus.jump_ack === 1'b1) ack_cnt++;
      if (bus.landed === 1'b1) begin
        land_cnt++;
        land_cyc      = cyc;
        ack_at_land   = bus.jump_ack;
        phase_at_land = bus.phase;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    bus.jump_req = 1'b1;
    bus.pause    = 1'b0;
    rst          = 1'b1;
    step(); step(); step();
    n_checks++;
    if (bus.ball_height !== 0 || bus.phase !== 0 || bus.airborne !== 0 ||
        bus.jump_ack !== 0 || bus.landed !== 0) begin
      n_fail++;
      $display("FAIL reset_outputs: h=%0d ph=%0d air=%0b ack=%0b land=%0b required all 0",
               bus.ball_height, bus.phase, bus.airborne, bus.jump_ack, bus.landed);
    end
    rst = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      n_checks++;
      if (bus.jump_ack !== 0 || bus.ball_height !== 0 || bus.phase !== 0) begin
        n_fail++;
        $display("FAIL held_level_after_reset: cycle %0d ack=%0b h=%0d ph=%0d required 0/0/0",
                 i, bus.jump_ack, bus.ball_height, bus.phase);
      end
    end
    bus.jump_req = 1'b0;
    step();
  endtask

  task automatic test_single_jump();
    int ack_c;
    int exp_gap[10] = '{4, 4, 4, 4, 4, 8, 4, 4, 4, 4};
    // Ack lands on a tick boundary so the flight lasts exactly 11 ticks.
    while (cyc % 4 != 3) step();
    bus.jump_req = 1'b1;
    step();
    ack_c = cyc;
    n_checks++;
    if (bus.jump_ack !== 1 || bus.phase !== 1 || bus.airborne !== 1 || bus.ball_height !== 0) begin
      n_fail++;
      $display("FAIL single_ack: ack=%0b ph=%0d air=%0b h=%0d required 1/1/1/0",
               bus.jump_ack, bus.phase, bus.airborne, bus.ball_height);
    end
    bus.jump_req = 1'b0;
    watch_landing(80);
    exp_q = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    n_checks++;
    if (h_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL single_height_count: got %0d changes required %0d", h_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < h_q.size(); i++) begin
      n_checks++;
      if (h_q[i] !== exp_q[i] || gap_q[i] != exp_gap[i]) begin
        n_fail++;
        $display("FAIL single_traj[%0d]: h=%0d after %0d cycles required h=%0d after %0d",
                 i, h_q[i], gap_q[i], exp_q[i], exp_gap[i]);
      end
    end
    n_checks++;
    if (ph_q.size() != 3 || ph_q[0] !== 2 || ph_q[1] !== 3 || ph_q[2] !== 0) begin
      n_fail++;
      $display("FAIL single_phases: got %0d changes, required sequence 2,3,0", ph_q.size());
    end
    n_checks++;
    if (land_cnt != 1 || land_cyc - ack_c != 44 || ack_cnt != 0) begin
      n_fail++;
      $display("FAIL single_landing: landed=%0d at +%0d cycles acks=%0d required 1 at +44, 0 acks",
               land_cnt, land_cyc - ack_c, ack_cnt);
    end
    step();
    n_checks++;
    if (bus.landed !== 0 || bus.phase !== 0 || bus.airborne !== 0) begin
      n_fail++;
      $display("FAIL single_after_land: landed=%0b ph=%0d air=%0b required 0/0/0",
               bus.landed, bus.phase, bus.airborne);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bus.jump_req = 1'b1;
    step();
    n_checks++;
    if (bus.jump_ack !== 1) begin
      n_fail++;
      $display("FAIL b2b_launch_ack: got %0b required 1", bus.jump_ack);
    end
    bus.jump_req = 1'b0;
    wait_hp(3'd1, 2'd3, 100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_reach_h1: timeout, h=%0d ph=%0d required 1/3", bus.ball_height, bus.phase);
    end
    bus.jump_req = 1'b1;
    step();
    n_checks++;
    if (bus.jump_ack !== 0 || bus.phase !== 3) begin
      n_fail++;
      $display("FAIL b2b_buffered_press: ack=%0b ph=%0d required 0/3", bus.jump_ack, bus.phase);
    end
    bus.jump_req = 1'b0;
    step(); step();
    n_checks++;
    if (bus.phase !== 3 || bus.landed !== 0 || bus.ball_height !== 1) begin
      n_fail++;
      $display("FAIL b2b_before_land: ph=%0d land=%0b h=%0d required 3/0/1",
               bus.phase, bus.landed, bus.ball_height);
    end
    step();
    n_checks++;
    if (bus.landed !== 1 || bus.jump_ack !== 1 || bus.phase !== 1 || bus.ball_height !== 0 ||
        bus.airborne !== 1) begin
      n_fail++;
      $display("FAIL b2b_land_relaunch: land=%0b ack=%0b ph=%0d h=%0d air=%0b required 1/1/1/0/1",
               bus.landed, bus.jump_ack, bus.phase, bus.ball_height, bus.airborne);
    end
    step();
    n_checks++;
    if (bus.landed !== 0 || bus.jump_ack !== 0 || bus.phase !== 1) begin
      n_fail++;
      $display("FAIL b2b_pulse_width: land=%0b ack=%0b ph=%0d required 0/0/1",
               bus.landed, bus.jump_ack, bus.phase);
    end
  endtask

  task automatic test_landing_edge();
    bit ok;
    wait_hp(3'd1, 2'd3, 100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL edge_reach_h1: timeout, h=%0d ph=%0d required 1/3", bus.ball_height, bus.phase);
    end
    step(); step(); step();
    bus.jump_req = 1'b1;
    step();
    n_checks++;
    if (bus.landed !== 1 || bus.jump_ack !== 1 || bus.phase !== 1 || bus.ball_height !== 0) begin
      n_fail++;
      $display("FAIL edge_on_landing_tick: land=%0b ack=%0b ph=%0d h=%0d required 1/1/1/0",
               bus.landed, bus.jump_ack, bus.phase, bus.ball_height);
    end
    bus.jump_req = 1'b0;
  endtask

  task automatic test_ignored_high();
    bit ok;
    wait_hp(3'd3, 2'd3, 100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL high_reach_h3: timeout, h=%0d ph=%0d required 3/3", bus.ball_height, bus.phase);
    end
    bus.jump_req = 1'b1;
    step();
    n_checks++;
    if (bus.jump_ack !== 0 || bus.phase !== 3) begin
      n_fail++;
      $display("FAIL high_press_ignored: ack=%0b ph=%0d required 0/3", bus.jump_ack, bus.phase);
    end
    bus.jump_req = 1'b0;
    watch_landing(60);
    n_checks++;
    if (land_cnt != 1 || ack_cnt != 0 || phase_at_land !== 0 || ack_at_land !== 0) begin
      n_fail++;
      $display("FAIL high_landing: landed=%0d acks=%0d ph=%0d ack_at_land=%0b required 1/0/0/0",
               land_cnt, ack_cnt, phase_at_land, ack_at_land);
    end
  endtask

  task automatic test_pause();
    bit ok;
    bus.jump_req = 1'b1;
    step();
    n_checks++;
    if (bus.jump_ack !== 1) begin
      n_fail++;
      $display("FAIL pause_launch_ack: got %0b required 1", bus.jump_ack);
    end
    bus.jump_req = 1'b0;
    wait_hp(3'd3, 2'd3, 100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL pause_reach_h3: timeout, h=%0d ph=%0d required 3/3", bus.ball_height, bus.phase);
    end
    bus.pause = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.jump_req = (i == 5);
      step();
      n_checks++;
      if (bus.ball_height !== 3 || bus.jump_ack !== 0 || bus.phase !== 3) begin
        n_fail++;
        $display("FAIL pause_frozen: cycle %0d h=%0d ack=%0b ph=%0d required 3/0/3",
                 i, bus.ball_height, bus.jump_ack, bus.phase);
      end
    end
    bus.jump_req = 1'b0;
    bus.pause    = 1'b0;
    step(); step(); step();
    n_checks++;
    if (bus.ball_height !== 3) begin
      n_fail++;
      $display("FAIL pause_prescaler_held: h=%0d 3 cycles after release required 3", bus.ball_height);
    end
    step();
    n_checks++;
    if (bus.ball_height !== 2 || bus.phase !== 3) begin
      n_fail++;
      $display("FAIL pause_resume: h=%0d ph=%0d 4 cycles after release required 2/3",
               bus.ball_height, bus.phase);
    end
    // A press in the buffer window while paused must not be remembered.
    wait_hp(3'd1, 2'd3, 20, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL pause_reach_h1: timeout, h=%0d ph=%0d required 1/3", bus.ball_height, bus.phase);
    end
    bus.pause    = 1'b1;
    bus.jump_req = 1'b1;
    step();
    bus.jump_req = 1'b0;
    step();
    bus.pause    = 1'b0;
    watch_landing(20);
    n_checks++;
    if (land_cnt != 1 || ack_cnt != 0 || phase_at_land !== 0 || ack_at_land !== 0) begin
      n_fail++;
      $display("FAIL pause_no_buffer: landed=%0d acks=%0d ph=%0d ack_at_land=%0b required 1/0/0/0",
               land_cnt, ack_cnt, phase_at_land, ack_at_land);
    end
  endtask

`ifdef JUMP_CTRL_DOUBLE_JUMP_EN
  task automatic test_double_jump();
    bit ok;
    bus.jump_req = 1'b1;
    step();
    bus.jump_req = 1'b0;
    wait_hp(3'd5, 2'd2, 100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL dj_reach_apex: timeout, h=%0d ph=%0d required 5/2", bus.ball_height, bus.phase);
    end
    bus.jump_req = 1'b1;
    step();
    n_checks++;
    if (bus.jump_ack !== 1 || bus.phase !== 1 || bus.ball_height !== 5) begin
      n_fail++;
      $display("FAIL dj_apex_press: ack=%0b ph=%0d h=%0d required 1/1/5",
               bus.jump_ack, bus.phase, bus.ball_height);
    end
    bus.jump_req = 1'b0;
    step();
    bus.jump_req = 1'b1;
    step();
    n_checks++;
    if (bus.jump_ack !== 0 || bus.phase !== 1) begin
      n_fail++;
      $display("FAIL dj_second_press: ack=%0b ph=%0d required 0/1", bus.jump_ack, bus.phase);
    end
    bus.jump_req = 1'b0;
    watch_landing(60);
    exp_q = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    n_checks++;
    if (h_q != exp_q || ph_q.size() != 3 || ph_q[0] !== 2 || ph_q[1] !== 3 || ph_q[2] !== 0) begin
      n_fail++;
      $display("FAIL dj_trajectory: %0d height changes %0d phase changes, required 4,3,2,1,0 and 2,3,0",
               h_q.size(), ph_q.size());
    end
    n_checks++;
    if (land_cnt != 1 || ack_cnt != 0) begin
      n_fail++;
      $display("FAIL dj_landing: landed=%0d acks=%0d required 1/0", land_cnt, ack_cnt);
    end
  endtask
`else
  task automatic test_apex_ignored();
    bit ok;
    bus.jump_req = 1'b1;
    step();
    bus.jump_req = 1'b0;
    wait_hp(3'd5, 2'd2, 100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL apex_reach: timeout, h=%0d ph=%0d required 5/2", bus.ball_height, bus.phase);
    end
    bus.jump_req = 1'b1;
    step();
    n_checks++;
    if (bus.jump_ack !== 0 || bus.phase !== 2 || bus.ball_height !== 5) begin
      n_fail++;
      $display("FAIL apex_press_ignored: ack=%0b ph=%0d h=%0d required 0/2/5",
               bus.jump_ack, bus.phase, bus.ball_height);
    end
    bus.jump_req = 1'b0;
    watch_landing(60);
    exp_q = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    n_checks++;
    if (h_q != exp_q || land_cnt != 1 || ack_cnt != 0 || phase_at_land !== 0) begin
      n_fail++;
      $display("FAIL apex_landing: %0d height changes landed=%0d acks=%0d ph=%0d required 4,3,2,1,0 / 1/0/0",
               h_q.size(), land_cnt, ack_cnt, phase_at_land);
    end
  endtask
`endif

  task automatic test_midair_reset();
    bit ok;
    bus.jump_req = 1'b1;
    step();
    bus.jump_req = 1'b0;
    wait_hp(3'd2, 2'd1, 100, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL midair_reach: timeout, h=%0d ph=%0d required 2/1", bus.ball_height, bus.phase);
    end
    rst = 1'b1;
    step();
    n_checks++;
    if (bus.ball_height !== 0 || bus.phase !== 0 || bus.landed !== 0 || bus.airborne !== 0) begin
      n_fail++;
      $display("FAIL midair_reset: h=%0d ph=%0d land=%0b air=%0b required 0/0/0/0",
               bus.ball_height, bus.phase, bus.landed, bus.airborne);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_checks++;
      if (bus.landed !== 0 || bus.phase !== 0) begin
        n_fail++;
        $display("FAIL midair_after: cycle %0d land=%0b ph=%0d required 0/0",
                 i, bus.landed, bus.phase);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.jump_req = 1'b0;
    bus.pause    = 1'b0;
    test_reset();
    test_single_jump();
    test_back_to_back();
    test_landing_edge();
    test_ignored_high();
    test_pause();
`ifdef JUMP_CTRL_DOUBLE_JUMP_EN
    test_double_jump();
`else
    test_apex_ignored();
`endif
    test_midair_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
